pomdp_episode_ctrl: RTL and testbench
=====================================

# pomdp_episode_ctrl

Parametrised episode sequencer for the PBVI/POMDP simulator. It runs a multi-step episode of at most `max_steps` steps, one after another, over three external units: decision, environment (state/observation/reward generation) and belief update. Each unit is driven through a start/done pulse handshake. The block keeps the current hidden state and accumulates undiscounted and discounted reward. It supports generic state/action/observation counts, early stop on a terminal state, and a watchdog abort.

## Interface
- `NS`, 2: number of hidden states; `SW = max(1,$clog2(NS))`.
- `NA`, 3: number of actions; `AW = max(1,$clog2(NA))`.
- `NO`, 2: number of observations; `OW = max(1,$clog2(NO))`.
- `W`, 16: reward and discount width; discount is unsigned Q0.W.
- `ACC_W`, 32: reward accumulator width; `ACC_W >= W`.
- `STEP_W`, 8: step counter width.
- `TIMEOUT`, 0: watchdog limit in cycles per wait state; 0 disables the watchdog.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: start or restart an episode; 1-cycle pulse.
- `max_steps` in STEP_W: episode length; sampled on `start`.
- `gamma` in W: discount factor Q0.W; sampled on `start`.
- `init_state` in SW: initial hidden state; sampled on `start`.
- `term_en` in 1, `term_state` in SW: terminal-state stop; sampled on `start`.
- `dec_start` out 1, `dec_done` in 1, `dec_action` in AW: decision handshake.
- `env_start` out 1, `env_state` out SW, `env_action` out AW: environment request.
- `env_done` in 1, `env_next_state` in SW, `env_reward` in W, `env_obs` in OW: environment response.
- `bel_start` out 1, `bel_action` out AW, `bel_obs` out OW, `bel_done` in 1: belief handshake.
- `busy` out 1: high in any state other than IDLE and DONE.
- `done` out 1: 1-cycle pulse when an episode ends.
- `err_timeout` out 1: sticky until the next `start`.
- `step_count` out STEP_W, `cur_state` out SW, `action` out AW: current episode status.
- `total_reward` out ACC_W, `disc_reward` out ACC_W: accumulated rewards.

## Operation
- FSM states: IDLE, DECIDE, ENV, BELIEF, ACCUM, DONE.
- `start` in IDLE or DONE performs the episode initialisation:
  - clears `step_count`, both accumulators and `err_timeout`;
  - sets `cur_state` to `init_state` and `disc` to 2^W-1;
  - goes to DECIDE, or directly to DONE if `max_steps` is 0.
- `start` in DECIDE, ENV, BELIEF or ACCUM aborts the episode: same initialisation, no `done` pulse for the aborted episode.
- DECIDE: `dec_start` high on the entry cycle only. On `dec_done`, latch `dec_action` into `action` and go to ENV.
- ENV: `env_start` high on the entry cycle only; `env_state = cur_state`, `env_action = action`. On `env_done`, latch next state, reward and observation, then go to BELIEF.
- BELIEF: `bel_start` high on the entry cycle only; `bel_action = action`, `bel_obs = latched observation`. On `bel_done`, go to ACCUM.
- Done inputs are ignored in the entry cycle of their state and in every other state.
- ACCUM lasts one cycle and performs:
  - `total_reward += r`;
  - `disc_reward += (r*disc)>>W`;
  - `disc = (disc*gamma)>>W`, using a full 2W-bit product truncated to W bits;
  - `cur_state = next`;
  - `step_count += 1`.
- Both accumulators saturate at 2^ACC_W-1.
- ACCUM exit: DONE if the new `step_count == max_steps`, or if `term_en` and `next == term_state`; otherwise DECIDE.
- DONE lasts one cycle: `done = 1`, then IDLE. Results hold until the next `start`.
- Watchdog (`TIMEOUT > 0`):
  - the counter clears on entry to DECIDE, ENV or BELIEF and increments each cycle in those states;
  - when it equals `TIMEOUT` with no done that cycle: set `err_timeout` and go to DONE;
  - a done arriving in that same cycle wins and no error is raised.

## Timing
- Reset values: FSM in IDLE; every output 0, including `cur_state`, `action` and `disc`.
- Reset asserted mid-episode aborts immediately; no `done` is produced.
- All outputs are registered. Start pulses are Moore outputs driven on the state-entry cycle.
- `start` is sampled at cycle 0, DECIDE is entered at cycle 1.
- With responders that answer 1 cycle after each start pulse, a step takes 7 cycles. The `done` pulse comes at cycle 7N+1 for N steps.
- `max_steps = 0`: `done` at cycle 1, all results 0.
- Accumulated results are visible in the cycle `done` is high.

## Test plan
- Wrap-around conditions:
  - NS=2, NA=3, W=16, `max_steps=3`, `gamma=0x8000`, reward 100 per step, 1-cycle responders;
  - expect `done` at cycle 22, `total_reward=300`, `disc_reward=99+49+24=172`, `step_count=3`.
- Terminal stop:
  - `term_en=1`, `term_state=1`, env returns next state 0 then 1, `max_steps=10`;
  - expect `done` after step 2, `step_count=2`, `cur_state=1`.
- Zero length: `max_steps=0` -> `done` at cycle 1, no start pulses, accumulators 0.
- Timeout:
  - `TIMEOUT=16`, `env_done` never asserted, ENV entered at cycle 3;
  - expect `err_timeout=1` and `done` at cycle 20.
- Saturation: `ACC_W=17`, reward 0xFFFF, `max_steps=4` -> `total_reward=0x1FFFF`.
- Abort and reset:
  - `start` during ENV restarts the episode with counters cleared and no `done`;
  - `rst_n` low in BELIEF forces all outputs to 0 and the FSM to IDLE.

Source files
------------

// File: rtl/pomdp_episode_ctrl.sv
// pomdp_episode_ctrl
// Episode sequencer for the PBVI/POMDP simulator. Runs up to max_steps steps,
// each one a decision -> environment -> belief-update handshake followed by a
// single accumulate cycle. Tracks the hidden state and accumulates undiscounted
// and discounted (Q0.W) reward with saturation. Supports early stop on a
// terminal state and a per-wait-state watchdog.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   start                           start/restart pulse (aborts a running episode)
//   max_steps, gamma, init_state,
//   term_en, term_state             episode configuration, sampled on start
//   dec_start/dec_done/dec_action   decision unit handshake
//   env_start/env_state/env_action  environment request
//   env_done/env_next_state/
//   env_reward/env_obs              environment response
//   bel_start/bel_action/bel_obs/
//   bel_done                        belief update handshake
//   busy, done, err_timeout         status (done is a 1-cycle pulse)
//   step_count, cur_state, action   episode progress
//   total_reward, disc_reward       saturating reward accumulators
module pomdp_episode_ctrl #(
  parameter int NS      = 2,
  parameter int NA      = 3,
  parameter int NO      = 2,
  parameter int W       = 16,
  parameter int ACC_W   = 32,
  parameter int STEP_W  = 8,
  parameter int TIMEOUT = 0,
  localparam int SW = (NS > 1) ? $clog2(NS) : 1,
  localparam int AW = (NA > 1) ? $clog2(NA) : 1,
  localparam int OW = (NO > 1) ? $clog2(NO) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [STEP_W-1:0] max_steps,
  input  logic [W-1:0]      gamma,
  input  logic [SW-1:0]     init_state,
  input  logic              term_en,
  input  logic [SW-1:0]     term_state,
  output logic              dec_start,
  input  logic              dec_done,
  input  logic [AW-1:0]     dec_action,
  output logic              env_start,
  output logic [SW-1:0]     env_state,
  output logic [AW-1:0]     env_action,
  input  logic              env_done,
  input  logic [SW-1:0]     env_next_state,
  input  logic [W-1:0]      env_reward,
  input  logic [OW-1:0]     env_obs,
  output logic              bel_start,
  output logic [AW-1:0]     bel_action,
  output logic [OW-1:0]     bel_obs,
  input  logic              bel_done,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [STEP_W-1:0] step_count,
  output logic [SW-1:0]     cur_state,
  output logic [AW-1:0]     action,
  output logic [ACC_W-1:0]  total_reward,
  output logic [ACC_W-1:0]  disc_reward
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECIDE, S_ENV, S_BELIEF, S_ACCUM, S_DONE
  } state_e;

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] WD_LIMIT = TW'(TIMEOUT);

  state_e state_q, state_d;

  logic              busy_q, done_q, err_q;
  logic              dec_start_q, env_start_q, bel_start_q;
  logic [STEP_W-1:0] step_q, max_q;
  logic [SW-1:0]     cur_q, next_q, term_q;
  logic              term_en_q;
  logic [AW-1:0]     act_q;
  logic [OW-1:0]     obs_q;
  logic [W-1:0]      rew_q, disc_q, gamma_q;
  logic [ACC_W-1:0]  tot_q, drew_q;
  logic [TW-1:0]     wd_q;

  logic              restart, enter;
  logic              dec_acc, env_acc, bel_acc, wd_fire, wd_hit;
  logic [STEP_W-1:0] step_inc;
  logic              term_hit;
  logic [2*W-1:0]    prod_rd, prod_dg;
  logic [W-1:0]      disc_d;
  logic [ACC_W:0]    tot_sum, drew_sum;
  logic [ACC_W-1:0]  tot_d, drew_d;

  assign wd_hit = (TIMEOUT > 0) && (wd_q == WD_LIMIT);

  // Accumulate-cycle arithmetic: both products are full 2W-bit, scaled back by W.
  always_comb begin
    step_inc = step_q + STEP_W'(1);
    term_hit = term_en_q && (next_q == term_q);
    prod_rd  = (2*W)'(rew_q) * (2*W)'(disc_q);
    prod_dg  = (2*W)'(disc_q) * (2*W)'(gamma_q);
    disc_d   = W'(prod_dg >> W);
    tot_sum  = (ACC_W+1)'(tot_q) + (ACC_W+1)'(rew_q);
    drew_sum = (ACC_W+1)'(drew_q) + (ACC_W+1)'(W'(prod_rd >> W));
    tot_d    = tot_sum[ACC_W]  ? '1 : tot_sum[ACC_W-1:0];
    drew_d   = drew_sum[ACC_W] ? '1 : drew_sum[ACC_W-1:0];
  end

  // Done inputs are qualified by !*_start_q so the entry cycle never accepts them.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    dec_acc = 1'b0;
    env_acc = 1'b0;
    bel_acc = 1'b0;
    wd_fire = 1'b0;
    case (state_q)
      S_DECIDE: begin
        if (dec_done && !dec_start_q) begin
          dec_acc = 1'b1;
          state_d = S_ENV;
        end else if (wd_hit) begin
          wd_fire = 1'b1;
          state_d = S_DONE;
        end
      end
      S_ENV: begin
        if (env_done && !env_start_q) begin
          env_acc = 1'b1;
          state_d = S_BELIEF;
        end else if (wd_hit) begin
          wd_fire = 1'b1;
          state_d = S_DONE;
        end
      end
      S_BELIEF: begin
        if (bel_done && !bel_start_q) begin
          bel_acc = 1'b1;
          state_d = S_ACCUM;
        end else if (wd_hit) begin
          wd_fire = 1'b1;
          state_d = S_DONE;
        end
      end
      S_ACCUM: state_d = (step_inc == max_q || term_hit) ? S_DONE : S_DECIDE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = state_q;
    endcase
    // start overrides everything, including an abort of a running episode
    if (start) begin
      restart = 1'b1;
      state_d = (max_steps == '0) ? S_DONE : S_DECIDE;
    end
    // a restart into the same state still counts as a fresh entry
    enter = restart || (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dec_start_q <= 1'b0;
      env_start_q <= 1'b0;
      bel_start_q <= 1'b0;
      step_q      <= '0;
      max_q       <= '0;
      cur_q       <= '0;
      next_q      <= '0;
      term_q      <= '0;
      term_en_q   <= 1'b0;
      act_q       <= '0;
      obs_q       <= '0;
      rew_q       <= '0;
      disc_q      <= '0;
      gamma_q     <= '0;
      tot_q       <= '0;
      drew_q      <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= state_d inside {S_DECIDE, S_ENV, S_BELIEF, S_ACCUM};
      done_q      <= (state_d == S_DONE);
      dec_start_q <= enter && (state_d == S_DECIDE);
      env_start_q <= enter && (state_d == S_ENV);
      bel_start_q <= enter && (state_d == S_BELIEF);

      if (enter) begin
        wd_q <= '0;
      end else if ((TIMEOUT > 0) && (state_q inside {S_DECIDE, S_ENV, S_BELIEF})) begin
        wd_q <= wd_q + TW'(1);
      end

      if (restart) begin
        step_q    <= '0;
        tot_q     <= '0;
        drew_q    <= '0;
        err_q     <= 1'b0;
        cur_q     <= init_state;
        disc_q    <= '1;
        max_q     <= max_steps;
        gamma_q   <= gamma;
        term_en_q <= term_en;
        term_q    <= term_state;
      end else begin
        if (dec_acc) act_q <= dec_action;
        if (env_acc) begin
          next_q <= env_next_state;
          rew_q  <= env_reward;
          obs_q  <= env_obs;
        end
        if (wd_fire) err_q <= 1'b1;
        if (state_q == S_ACCUM) begin
          tot_q  <= tot_d;
          drew_q <= drew_d;
          disc_q <= disc_d;
          cur_q  <= next_q;
          step_q <= step_inc;
        end
      end
    end
  end

  assign dec_start    = dec_start_q;
  assign env_start    = env_start_q;
  assign env_state    = cur_q;
  assign env_action   = act_q;
  assign bel_start    = bel_start_q;
  assign bel_action   = act_q;
  assign bel_obs      = obs_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_timeout  = err_q;
  assign step_count   = step_q;
  assign cur_state    = cur_q;
  assign action       = act_q;
  assign total_reward = tot_q;
  assign disc_reward  = drew_q;

endmodule

// File: tb/tb_pomdp_episode_ctrl.sv
// Testbench for pomdp_episode_ctrl: directed scenarios (discounting, terminal
// stop, zero length, watchdog, saturation, abort, reset) plus randomized
// episodes, checked against an episode-level reference model.
module tb_pomdp_episode_ctrl;

  localparam int W = 16, ACC_W = 17, STEP_W = 8, TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n, start;
  logic [STEP_W-1:0] max_steps;
  logic [W-1:0]      gamma;
  logic              init_state, term_en, term_state;
  logic              dec_start, dec_done;
  logic [1:0]        dec_action;
  logic              env_start, env_state;
  logic [1:0]        env_action;
  logic              env_done, env_next_state;
  logic [W-1:0]      env_reward;
  logic              env_obs;
  logic              bel_start;
  logic [1:0]        bel_action;
  logic              bel_obs, bel_done;
  logic              busy, done, err_timeout;
  logic [STEP_W-1:0] step_count;
  logic              cur_state;
  logic [1:0]        action;
  logic [ACC_W-1:0]  total_reward, disc_reward;

  always #5 clk = ~clk;

  pomdp_episode_ctrl #(
    .NS(2), .NA(3), .NO(2), .W(W), .ACC_W(ACC_W), .STEP_W(STEP_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_steps(max_steps), .gamma(gamma),
    .init_state(init_state), .term_en(term_en), .term_state(term_state),
    .dec_start(dec_start), .dec_done(dec_done), .dec_action(dec_action),
    .env_start(env_start), .env_state(env_state), .env_action(env_action),
    .env_done(env_done), .env_next_state(env_next_state), .env_reward(env_reward),
    .env_obs(env_obs), .bel_start(bel_start), .bel_action(bel_action),
    .bel_obs(bel_obs), .bel_done(bel_done), .busy(busy), .done(done),
    .err_timeout(err_timeout), .step_count(step_count), .cur_state(cur_state),
    .action(action), .total_reward(total_reward), .disc_reward(disc_reward)
  );

  int total = 0, bad = 0;
  int unsigned rew_a[16], nxt_a[16], obs_a[16], act_a[16];
  int ld = 1, le = 1, lb = 1;
  bit env_mute = 1'b0;
  int dec_pend = 0, env_pend = 0, bel_pend = 0;
  int dec_idx = 0, env_idx = 0, bel_idx = 0, dec_pulses = 0;
  int unsigned init_v = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic rsp_clear();
    dec_pend = 0; env_pend = 0; bel_pend = 0;
    dec_idx = 0; env_idx = 0; bel_idx = 0; dec_pulses = 0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      rew_a[i] = $urandom_range(0, 65535);
      nxt_a[i] = $urandom_range(0, 1);
      obs_a[i] = $urandom_range(0, 1);
      act_a[i] = $urandom_range(0, 2);
    end
  endtask

  // Responders: sample DUT outputs 2 time units after the edge, answer L cycles
  // after each start pulse, and check the request fields against the episode data.
  initial begin
    dec_done = 1'b0; dec_action = '0; env_done = 1'b0; env_next_state = 1'b0;
    env_reward = '0; env_obs = 1'b0; bel_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      dec_done = 1'b0; env_done = 1'b0; bel_done = 1'b0;
      if (dec_pend > 0) begin
        dec_pend--;
        if (dec_pend == 0) begin
          dec_done = 1'b1; dec_action = 2'(act_a[dec_idx % 16]); dec_idx++;
        end
      end
      if (dec_start === 1'b1) begin dec_pend = ld; dec_pulses++; end
      if (env_pend > 0) begin
        env_pend--;
        if (env_pend == 0 && !env_mute) begin
          env_done = 1'b1;
          env_next_state = 1'(nxt_a[env_idx % 16]);
          env_reward = 16'(rew_a[env_idx % 16]);
          env_obs = 1'(obs_a[env_idx % 16]);
          env_idx++;
        end
      end
      if (env_start === 1'b1) begin
        chk("env_state", 64'(env_state), (env_idx == 0) ? 64'(init_v) : 64'(nxt_a[(env_idx - 1) % 16]));
        chk("env_action", 64'(env_action), 64'(act_a[env_idx % 16]));
        env_pend = le;
      end
      if (bel_pend > 0) begin
        bel_pend--;
        if (bel_pend == 0) begin bel_done = 1'b1; bel_idx++; end
      end
      if (bel_start === 1'b1) begin
        chk("bel_action", 64'(bel_action), 64'(act_a[bel_idx % 16]));
        chk("bel_obs", 64'(bel_obs), 64'(obs_a[bel_idx % 16]));
        bel_pend = lb;
      end
    end
  end

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 400; i++) begin
      if (done === 1'b1) begin dc = cyc; break; end
      @(negedge clk); cyc++;
    end
  endtask

  // Called at a negedge: that cycle is cycle 0.
  task automatic run_ep(input int ms, input int g, input int init, input int ten,
                        input int ts, output int dc);
    rsp_clear();
    init_v = init;
    max_steps = 8'(ms); gamma = 16'(g); init_state = 1'(init);
    term_en = 1'(ten); term_state = 1'(ts); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    wait_done(dc);
  endtask

  // Episode-level reference: walk the step list with plain arithmetic.
  task automatic model_chk(input string tag, input int ms, input int g, input int init,
                           input int ten, input int ts, input int dc);
    longint unsigned tot, dr, disc, r, mx;
    int n, st, a;
    mx = (64'd1 << ACC_W) - 1;
    disc = 65535; tot = 0; dr = 0; st = init; n = 0; a = 0;
    for (int i = 0; i < ms; i++) begin
      r = rew_a[i];
      tot = tot + r; if (tot > mx) tot = mx;
      dr = dr + ((r * disc) >> 16); if (dr > mx) dr = mx;
      disc = (disc * longint'(g)) >> 16;
      st = nxt_a[i]; a = act_a[i]; n = i + 1;
      if (ten != 0 && st == ts) break;
    end
    chk({tag, "_cycle"}, 64'(dc), 64'(1 + n * (ld + le + lb + 4)));
    chk({tag, "_steps"}, 64'(step_count), 64'(n));
    chk({tag, "_state"}, 64'(cur_state), 64'(st));
    chk({tag, "_total"}, 64'(total_reward), tot);
    chk({tag, "_disc"}, 64'(disc_reward), dr);
    chk({tag, "_err"}, 64'(err_timeout), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_decs"}, 64'(dec_pulses), 64'(n));
    if (n > 0) chk({tag, "_action"}, 64'(action), 64'(a));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int dc, seen, dn;
    rst_n = 1'b0; start = 1'b0; max_steps = '0; gamma = '0;
    init_state = 1'b0; term_en = 1'b0; term_state = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_steps", 64'(step_count), 64'd0);
    chk("rst_total", 64'(total_reward), 64'd0);
    chk("rst_disc", 64'(disc_reward), 64'd0);
    chk("rst_starts", 64'({dec_start, env_start, bel_start}), 64'd0);
    rst_n = 1'b1;

    // Discounting: 3 steps, gamma 0.5, reward 100
    for (int i = 0; i < 16; i++) begin
      rew_a[i] = 100; nxt_a[i] = i % 2; obs_a[i] = (i + 1) % 2; act_a[i] = (i % 3);
    end
    ld = 1; le = 1; lb = 1;
    run_ep(3, 'h8000, 0, 0, 0, dc);
    chk("wrap_cycle", 64'(dc), 64'd22);
    chk("wrap_total", 64'(total_reward), 64'd300);
    chk("wrap_disc", 64'(disc_reward), 64'd172);
    chk("wrap_steps", 64'(step_count), 64'd3);
    @(negedge clk);
    chk("wrap_done_pulse", 64'(done), 64'd0);
    chk("wrap_hold", 64'(total_reward), 64'd300);

    // Terminal stop after step 2
    nxt_a[0] = 0; nxt_a[1] = 1;
    run_ep(10, 'h8000, 0, 1, 1, dc);
    chk("term_cycle", 64'(dc), 64'd15);
    chk("term_steps", 64'(step_count), 64'd2);
    chk("term_state", 64'(cur_state), 64'd1);
    @(negedge clk);

    // Zero length
    run_ep(0, 'h1234, 0, 0, 0, dc);
    chk("zero_cycle", 64'(dc), 64'd1);
    chk("zero_total", 64'(total_reward), 64'd0);
    chk("zero_disc", 64'(disc_reward), 64'd0);
    chk("zero_decs", 64'(dec_pulses), 64'd0);
    @(negedge clk);

    // Watchdog: environment never answers
    env_mute = 1'b1;
    run_ep(5, 'h8000, 0, 0, 0, dc);
    chk("tmo_cycle", 64'(dc), 64'd20);
    chk("tmo_err", 64'(err_timeout), 64'd1);
    chk("tmo_steps", 64'(step_count), 64'd0);
    env_mute = 1'b0;
    @(negedge clk);
    chk("tmo_sticky", 64'(err_timeout), 64'd1);

    // Saturation at ACC_W=17
    for (int i = 0; i < 16; i++) rew_a[i] = 'hFFFF;
    run_ep(4, 'hFFFF, 1, 0, 0, dc);
    chk("sat_total", 64'(total_reward), 64'h1FFFF);
    model_chk("sat", 4, 'hFFFF, 1, 0, 0, dc);
    @(negedge clk);

    // Abort during ENV of step 2
    fill_rand(); rew_a[0] = 500;
    rsp_clear(); init_v = 0;
    max_steps = 8'd6; gamma = 16'hC000; init_state = 1'b0; term_en = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0; dn = 0;
    for (int i = 0; i < 200 && seen < 2; i++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
      if (env_start === 1'b1) seen++;
    end
    chk("abort_reach_env", 64'(seen), 64'd2);
    chk("abort_pre_total", 64'(total_reward), 64'(rew_a[0]));
    rsp_clear(); init_v = 1;
    max_steps = 8'd4; gamma = 16'hA000; init_state = 1'b1; term_en = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    chk("abort_steps_clr", 64'(step_count), 64'd0);
    chk("abort_total_clr", 64'(total_reward), 64'd0);
    chk("abort_disc_clr", 64'(disc_reward), 64'd0);
    chk("abort_dec_start", 64'(dec_start), 64'd1);
    wait_done(dc);
    chk("abort_no_done", 64'(dn), 64'd0);
    model_chk("abort", 4, 'hA000, 1, 0, 0, dc);
    @(negedge clk);

    // Reset asserted in BELIEF of step 2
    fill_rand(); rew_a[0] = 500;
    for (int i = 0; i < 16; i++) act_a[i] = $urandom_range(1, 2);
    rsp_clear(); init_v = 1;
    max_steps = 8'd5; gamma = 16'h8000; init_state = 1'b1; term_en = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && seen < 2; i++) begin
      @(negedge clk);
      if (bel_start === 1'b1) seen++;
    end
    chk("rst_reach_bel", 64'(seen), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_steps", 64'(step_count), 64'd0);
    chk("arst_state_act", 64'({cur_state, action}), 64'd0);
    chk("arst_total", 64'(total_reward), 64'd0);
    chk("arst_starts", 64'({dec_start, env_start, bel_start, done, err_timeout}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; rsp_clear();
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    chk("rst_quiet", 64'(dn), 64'd0);

    // Randomized episodes
    for (int e = 0; e < 8; e++) begin
      int ms, g, init, ten, ts;
      fill_rand();
      if (e % 2 == 1) for (int i = 0; i < 16; i++) rew_a[i] = $urandom_range(0, 4000);
      ld = $urandom_range(1, 3); le = $urandom_range(1, 3); lb = $urandom_range(1, 3);
      ms = (e == 5) ? 0 : $urandom_range(1, 12);
      g = $urandom_range(0, 65535); init = $urandom_range(0, 1);
      ten = $urandom_range(0, 1); ts = $urandom_range(0, 1);
      run_ep(ms, g, init, ten, ts, dc);
      model_chk("rand", ms, g, init, ten, ts, dc);
      @(negedge clk);
      chk("rand_done_pulse", 64'(done), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
